clock_ena_gen: RTL and testbench

CLOCK_ENA_GEN -- requirements
Module: clock_ena_gen

---
 rtl/clock_ena_gen.sv | 102 ++++++++++
 tb/tb_clock_ena_gen.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/clock_ena_gen.sv
// Purpose: fractional clock-enable generator; N/D accumulators gated by a settled PLL lock.
// Latency: ENA is registered; READY rises SETTLE_CYCLES+2 edges after LOCK_IN is first sampled high.
// Backpressure: none; UPDATE is accepted on any edge and restarts all channels in phase.
module clock_ena_gen #(
  parameter int CHANNELS      = 2,
  parameter int ACC_WIDTH     = 16,
  parameter int SETTLE_CYCLES = 1024
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          LOCK_IN,
  input  logic                          UPDATE,
  input  logic [CHANNELS*ACC_WIDTH-1:0] NUM,
  input  logic [CHANNELS*ACC_WIDTH-1:0] DEN,
  output logic                          READY,
  output logic [CHANNELS-1:0]           ENA,
  output logic [CHANNELS-1:0]           ERR
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] SETTLE_MAX = CW'(SETTLE_CYCLES);

  logic          lock_meta;
  logic          lock_sync;
  logic [CW-1:0] settle_cnt;
  logic [CW-1:0] settle_cnt_nxt;
  logic          ready_nxt;

  logic [ACC_WIDTH-1:0] num_act [CHANNELS];
  logic [ACC_WIDTH-1:0] den_act [CHANNELS];
  logic [ACC_WIDTH-1:0] acc     [CHANNELS];
  logic [ACC_WIDTH-1:0] acc_nxt [CHANNELS];
  logic [ACC_WIDTH:0]   sum     [CHANNELS];
  logic [CHANNELS-1:0]  wrap;

  // Saturating settle count; any unlocked cycle restarts it.
  // READY follows the next-state count so ENA is gated in the same cycle READY changes.
  always_comb begin
    settle_cnt_nxt = '0;
    if (lock_sync) begin
      settle_cnt_nxt = (settle_cnt == SETTLE_MAX) ? SETTLE_MAX : settle_cnt + 1'b1;
    end
    ready_nxt = lock_sync && (settle_cnt_nxt == SETTLE_MAX);
  end

  // Lock synchroniser, settle counter and READY register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      lock_meta  <= 1'b0;
      lock_sync  <= 1'b0;
      settle_cnt <= '0;
      READY      <= 1'b0;
    end else begin
      lock_meta  <= LOCK_IN;
      lock_sync  <= lock_meta;
      settle_cnt <= settle_cnt_nxt;
      READY      <= ready_nxt;
    end
  end

  // Accumulate step per channel: the sum is one bit wider so the compare never overflows.
  // The wrapped value fits in ACC_WIDTH because ACC < DEN and NUM <= DEN, so the
  // modular subtraction below is exact.
  always_comb begin
    for (int n = 0; n < CHANNELS; n++) begin
      sum[n]     = {1'b0, acc[n]} + {1'b0, num_act[n]};
      wrap[n]    = (sum[n] >= {1'b0, den_act[n]});
      acc_nxt[n] = wrap[n] ? (acc[n] + num_act[n] - den_act[n]) : (acc[n] + num_act[n]);
    end
  end

  // Per-channel configuration, error flag, accumulator and enable; UPDATE wins over stepping.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int n = 0; n < CHANNELS; n++) begin
        num_act[n] <= '0;
        den_act[n] <= ACC_WIDTH'(1);
        acc[n]     <= '0;
      end
      ENA <= '0;
      ERR <= '0;
    end else begin
      for (int n = 0; n < CHANNELS; n++) begin
        if (UPDATE) begin
          num_act[n] <= NUM[n*ACC_WIDTH +: ACC_WIDTH];
          den_act[n] <= DEN[n*ACC_WIDTH +: ACC_WIDTH];
          ERR[n]     <= (DEN[n*ACC_WIDTH +: ACC_WIDTH] == '0) ||
                        (NUM[n*ACC_WIDTH +: ACC_WIDTH] > DEN[n*ACC_WIDTH +: ACC_WIDTH]);
          acc[n]     <= '0;
          ENA[n]     <= 1'b0;
        end else if (!ready_nxt || ERR[n]) begin
          acc[n]     <= '0;
          ENA[n]     <= 1'b0;
        end else begin
          acc[n]     <= acc_nxt[n];
          ENA[n]     <= wrap[n];
        end
      end
    end
  end

endmodule

// File: tb/tb_clock_ena_gen.sv
// Purpose: self-checking bench for clock_ena_gen (settle timing, ratios, errors, update, reset).
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: none; expected pulse positions are queued per scenario and popped as ENA fires.
module tb_clock_ena_gen;
  localparam int CH = 2;
  localparam int W  = 16;
  localparam int S  = 4;

  logic            CLK = 1'b0;
  logic            RESET = 1'b1;
  logic            LOCK_IN = 1'b0;
  logic            UPDATE = 1'b0;
  logic [CH*W-1:0] NUM = '0;
  logic [CH*W-1:0] DEN = '0;
  logic            READY;
  logic [CH-1:0]   ENA;
  logic [CH-1:0]   ERR;

  int tests = 0;
  int fails = 0;
  int q0[$];
  int q1[$];
  logic [CH-1:0] qe[$];

  clock_ena_gen #(.CHANNELS(CH), .ACC_WIDTH(W), .SETTLE_CYCLES(S)) dut (
    .CLK(CLK), .RESET(RESET), .LOCK_IN(LOCK_IN), .UPDATE(UPDATE),
    .NUM(NUM), .DEN(DEN), .READY(READY), .ENA(ENA), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Ideal pulse placement for ratio n/d starting at phase 0: pulse on step k when floor crosses.
  function automatic bit pulse_at(int n, int d, int k);
    return ((k * n) / d) != (((k - 1) * n) / d);
  endfunction

  task automatic load(input int n0, input int d0, input int n1, input int d1);
    NUM = {W'(n1), W'(n0)};
    DEN = {W'(d1), W'(d0)};
    UPDATE = 1'b1;
    tick();
    UPDATE = 1'b0;
  endtask

  task automatic wait_ready(input logic v, input int budget, output bit ok, output int edges);
    ok = 1'b0;
    edges = 0;
    while (edges < budget && !ok) begin
      tick();
      edges++;
      if (READY === v) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    #2;
    tests++; if (READY !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b want 0", READY); end
    tests++; if (ENA !== 2'b00) begin fails++; $display("FAIL reset_ena: got %b want 00", ENA); end
    tests++; if (ERR !== 2'b00) begin fails++; $display("FAIL reset_err: got %b want 00", ERR); end
    tick();
    tick();
    RESET = 1'b0;
  endtask

  task automatic test_settle();
    LOCK_IN = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      tick();
      tests++;
      if (READY !== (e == 6)) begin
        fails++; $display("FAIL settle_rise: edge %0d READY=%b want %b", e, READY, (e == 6));
      end
    end
    // Idle defaults after reset: NUM=0, DEN=1 means no pulses and no error.
    tests++; if (ENA !== 2'b00 || ERR !== 2'b00) begin
      fails++; $display("FAIL idle_defaults: ENA=%b ERR=%b want 00/00", ENA, ERR);
    end
    LOCK_IN = 1'b0;
    tick();
    LOCK_IN = 1'b1;
    tick();
    tests++; if (READY !== 1'b1) begin fails++; $display("FAIL glitch_hold: READY=%b want 1", READY); end
    tick();
    tests++; if (READY !== 1'b0) begin fails++; $display("FAIL glitch_drop: READY=%b want 0", READY); end
    for (int e = 1; e <= 4; e++) begin
      tick();
      tests++;
      if (READY !== (e == 4)) begin
        fails++; $display("FAIL resettle: edge %0d READY=%b want %b", e, READY, (e == 4));
      end
    end
  endtask

  task automatic test_ratio();
    bit ok;
    int edges, c0, c1, exp, ready_bad;
    LOCK_IN = 1'b0;
    wait_ready(1'b0, 10, ok, edges);
    tests++; if (!ok) begin fails++; $display("FAIL ratio_unlock: READY=%b want 0", READY); end
    tests++; if (ENA !== 2'b00) begin fails++; $display("FAIL ratio_unlock_ena: got %b want 00", ENA); end
    load(1, 5, 1, 30);
    tests++; if (ERR !== 2'b00) begin fails++; $display("FAIL ratio_err: got %b want 00", ERR); end
    for (int k = 1; k <= 300; k++) begin
      if (pulse_at(1, 5, k)) q0.push_back(k);
      if (pulse_at(1, 30, k)) q1.push_back(k);
    end
    LOCK_IN = 1'b1;
    wait_ready(1'b1, 20, ok, edges);
    tests++; if (!ok || edges != 6) begin fails++; $display("FAIL ratio_settle: edges=%0d want 6", edges); end
    c0 = 0; c1 = 0; ready_bad = 0;
    for (int k = 1; k <= 300; k++) begin
      if (k > 1) tick();
      if (READY !== 1'b1) ready_bad++;
      if (ENA[0] === 1'b1) begin
        c0++;
        exp = (q0.size() > 0) ? q0.pop_front() : -1;
        tests++; if (exp != k) begin fails++; $display("FAIL ratio_ch0_pulse: at cycle %0d, expected %0d", k, exp); end
      end
      if (ENA[1] === 1'b1) begin
        c1++;
        exp = (q1.size() > 0) ? q1.pop_front() : -1;
        tests++; if (exp != k) begin fails++; $display("FAIL ratio_ch1_pulse: at cycle %0d, expected %0d", k, exp); end
      end
    end
    tests++; if (c0 != 60 || q0.size() != 0) begin fails++; $display("FAIL ratio_ch0_count: got %0d want 60", c0); end
    tests++; if (c1 != 10 || q1.size() != 0) begin fails++; $display("FAIL ratio_ch1_count: got %0d want 10", c1); end
    tests++; if (ready_bad != 0) begin fails++; $display("FAIL ratio_ready: %0d low cycles want 0", ready_bad); end
    q0.delete(); q1.delete();
  endtask

  task automatic test_midrun_update();
    int c0, exp, last, bad_gap, misalign;
    for (int k = 1; k <= 1750; k++) if (pulse_at(44, 175, k)) q0.push_back(k);
    load(44, 175, 44, 175);
    tests++; if (ENA !== 2'b00) begin fails++; $display("FAIL update_ena: got %b want 00", ENA); end
    c0 = 0; last = -1; bad_gap = 0; misalign = 0;
    for (int k = 1; k <= 1750; k++) begin
      tick();
      if (ENA[0] !== ENA[1]) misalign++;
      if (ENA[0] === 1'b1) begin
        c0++;
        exp = (q0.size() > 0) ? q0.pop_front() : -1;
        tests++; if (exp != k) begin fails++; $display("FAIL frac_pulse: at cycle %0d, expected %0d", k, exp); end
        if (last >= 0 && (k - last) != 3 && (k - last) != 4) bad_gap++;
        last = k;
      end
    end
    tests++; if (c0 != 440 || q0.size() != 0) begin fails++; $display("FAIL frac_count: got %0d want 440", c0); end
    tests++; if (bad_gap != 0) begin fails++; $display("FAIL frac_gaps: %0d bad gaps want 0", bad_gap); end
    tests++; if (misalign != 0) begin fails++; $display("FAIL update_align: %0d misaligned cycles want 0", misalign); end
    q0.delete();
  endtask

  task automatic test_errors();
    int cfg [4][4] = '{'{3, 0, 7, 5}, '{3, 0, 1, 1}, '{9, 9, 0, 5}, '{0, 7, 5, 5}};
    logic [CH-1:0] exp_err [4] = '{2'b11, 2'b01, 2'b00, 2'b00};
    logic [CH-1:0] exp_ena [4] = '{2'b00, 2'b10, 2'b01, 2'b10};
    logic [CH-1:0] e;
    for (int t = 0; t < 4; t++) begin
      load(cfg[t][0], cfg[t][1], cfg[t][2], cfg[t][3]);
      tests++; if (ERR !== exp_err[t]) begin fails++; $display("FAIL err_flag[%0d]: got %b want %b", t, ERR, exp_err[t]); end
      tests++; if (ENA !== 2'b00) begin fails++; $display("FAIL err_update_ena[%0d]: got %b want 00", t, ENA); end
      for (int k = 0; k < 8; k++) qe.push_back(exp_ena[t]);
      while (qe.size() > 0) begin
        tick();
        e = qe.pop_front();
        tests++; if (ENA !== e) begin fails++; $display("FAIL err_ena[%0d]: got %b want %b", t, ENA, e); end
      end
    end
  endtask

  task automatic test_reset_midop();
    bit ok;
    int edges, bad;
    load(9, 9, 7, 5);
    tick();
    tick();
    tests++; if (ENA !== 2'b01 || ERR !== 2'b10) begin
      fails++; $display("FAIL pre_reset: ENA=%b ERR=%b want 01/10", ENA, ERR);
    end
    #2;
    RESET = 1'b1;
    #1;
    tests++; if (READY !== 1'b0 || ENA !== 2'b00 || ERR !== 2'b00) begin
      fails++; $display("FAIL async_reset: READY=%b ENA=%b ERR=%b want 0/00/00", READY, ENA, ERR);
    end
    tick();
    RESET = 1'b0;
    wait_ready(1'b1, 20, ok, edges);
    tests++; if (!ok || edges != 6) begin fails++; $display("FAIL post_reset_settle: edges=%0d want 6", edges); end
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      if (ENA !== 2'b00 || ERR !== 2'b00) bad++;
      tick();
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL post_reset_idle: %0d active cycles want 0", bad); end
  endtask

  initial begin
    test_reset();
    test_settle();
    test_ratio();
    test_midrun_update();
    test_errors();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
